// File: rtl/pma_pkg.sv
// Shared PMA definitions: code-group width, comma code-groups, serializer FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pma_pkg;

   // Code-group width and the matching bit-counter width
   localparam int CG_WIDTH  = 10;
   localparam int CNT_WIDTH = $clog2(CG_WIDTH);

   // K28.5 in both running disparities, written so that bit[0] is the first bit on the wire
   localparam logic [CG_WIDTH-1:0] K28_5_RDN = 10'h17C;
   localparam logic [CG_WIDTH-1:0] K28_5_RDP = 10'h283;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pma_state_t;

endpackage

// File: rtl/pma_tx_hold_buf.sv
// One-entry hold buffer sitting between PCS transmit and the serializer shift register.
// Latency: a written word is visible on hold_dat the cycle after the write edge.
// Backpressure: caller only writes when empty or draining; a write wins over a same-edge drain.
module pma_tx_hold_buf
   import pma_pkg::*;
#(
   parameter int CG_WIDTH = pma_pkg::CG_WIDTH
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_vld,
   input  logic [CG_WIDTH-1:0] wr_dat,
   input  logic                drain,
   output logic                hold_vld,
   output logic [CG_WIDTH-1:0] hold_dat
);

   // Capture on write; otherwise empty out when the serializer takes the word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_vld <= 1'b0;
         hold_dat <= '0;
      end else if (wr_vld) begin
         hold_vld <= 1'b1;
         hold_dat <= wr_dat;
      end else if (drain) begin
         hold_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/pma_tx_piso.sv
// TX PMA serializer: 10-bit code-groups out one bit per clk, bit[0] first, filler on underrun.
// Latency: first bit one cycle after tx_en is sampled; bypassed word starts the cycle after the boundary.
// Backpressure: load_ready = hold empty, or hold draining at an enabled code-group boundary.
module pma_tx_piso
   import pma_pkg::*;
#(
   parameter int                  CG_WIDTH   = pma_pkg::CG_WIDTH,
   parameter logic [CG_WIDTH-1:0] FILLER     = pma_pkg::K28_5_RDN,
   parameter int                  UCNT_WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_en,
   input  logic [CG_WIDTH-1:0]   parallel_in,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic                  s_out,
   output logic                  cg_start,
   output logic                  underrun,
   output logic [UCNT_WIDTH-1:0] underrun_count
);

   localparam int                 CNT_W    = $clog2(CG_WIDTH);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(CG_WIDTH - 1);

   pma_state_t          state;
   logic [CG_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]    bit_cnt;
   logic                hold_vld;
   logic [CG_WIDTH-1:0] hold_dat;

   logic boundary;     // last bit of the current code-group is on s_out
   logic next_cg;      // a new code-group is taken at this boundary (still enabled)
   logic start;        // IDLE -> RUN this edge
   logic transfer;     // parallel_in accepted this edge
   logic bypass;       // accepted word goes straight to the shift register
   logic underrun_evt; // nothing to send at an enabled boundary

   assign boundary     = (state == RUN) && (bit_cnt == LAST_BIT);
   assign next_cg      = boundary && tx_en;
   assign start        = (state == IDLE) && tx_en;
   assign load_ready   = !hold_vld || next_cg;
   assign transfer     = load_valid && load_ready;
   assign bypass       = next_cg && !hold_vld && transfer;
   assign underrun_evt = next_cg && !hold_vld && !transfer;

   // shift_reg is forced to zero in IDLE, so its LSB is the registered line state in both states
   assign s_out    = shift_reg[0];
   assign cg_start = (state == RUN) && (bit_cnt == '0);

   pma_tx_hold_buf #(
      .CG_WIDTH (CG_WIDTH)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .wr_vld   (transfer && !bypass),
      .wr_dat   (parallel_in),
      .drain    (start || next_cg),
      .hold_vld (hold_vld),
      .hold_dat (hold_dat)
   );

   // Serializer FSM: start/stop only on code-group boundaries, shift one bit per clk while running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (tx_en) begin
                  state     <= RUN;
                  shift_reg <= hold_vld ? hold_dat : FILLER;
               end
            end
            RUN: begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (!tx_en) begin
                     state     <= IDLE;
                     shift_reg <= '0;
                  end else if (hold_vld) begin
                     shift_reg <= hold_dat;
                  end else if (transfer) begin
                     shift_reg <= parallel_in;
                  end else begin
                     shift_reg <= FILLER;
                     underrun  <= 1'b1;
                  end
               end else begin
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= bit_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               shift_reg <= '0;
               bit_cnt   <= '0;
            end
         endcase
      end
   end

   // Saturating count of filler substitutions while running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (underrun_evt && (underrun_count != '1)) begin
         underrun_count <= underrun_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pma_tx_piso.sv
// Bench for pma_tx_piso: directed scenarios plus random traffic against a word-level stream model.
// Latency: model predicts code-group starts one cycle after tx_en is seen at an idle/boundary point.
// Backpressure: model treats the words accepted but not yet started as the hold contents.
module tb_pma_tx_piso;
   import pma_pkg::*;

   localparam logic [9:0] FILL = K28_5_RDN;

   logic       clk;
   logic       reset;
   logic       tx_en;
   logic [9:0] parallel_in;
   logic       load_valid;
   logic       load_ready;
   logic       s_out;
   logic       cg_start;
   logic       underrun;
   logic [7:0] underrun_count;

   int checks = 0;
   int errors = 0;

   pma_tx_piso dut (
      .clk            (clk),
      .reset          (reset),
      .tx_en          (tx_en),
      .parallel_in    (parallel_in),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .s_out          (s_out),
      .cg_start       (cg_start),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: timed out waiting", tag);
   endtask

   // ---------------- stream reference model ----------------
   // Words are sent in acceptance order; an empty queue at a start means FILLER,
   // and that counts as an underrun only if it directly follows a previous word.
   logic [9:0] mq[$];
   int         m_bit   = 10;   // index of bit on the line, 10 = no word in progress
   logic       m_pend  = 1'b0; // a code-group is due to start on the next sample
   logic       m_last  = 1'b0;
   logic [9:0] m_word  = '0;
   logic [9:0] m_rx    = '0;
   logic [9:0] m_nword = '0;
   logic       m_nund  = 1'b0;
   logic       m_und   = 1'b0;
   int         m_ucnt  = 0;

   task automatic take_word(input logic contiguous);
      if (mq.size() > 0) begin
         m_nword = mq.pop_front();
         m_nund  = 1'b0;
      end else begin
         m_nword = FILL;
         m_nund  = contiguous;
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_s_out", s_out, 0);
         chk("rst_cg_start", cg_start, 0);
         chk("rst_underrun", underrun, 0);
         chk("rst_ucount", underrun_count, 0);
         chk("rst_load_ready", load_ready, 1);
         mq.delete();
         m_bit  = 10;
         m_pend = 1'b0;
         m_last = 1'b0;
         m_ucnt = 0;
      end else begin
         chk("cg_start", cg_start, m_pend);
         m_und = 1'b0;
         if (m_pend) begin
            m_word = m_nword;
            m_und  = m_nund;
            if (m_und && m_ucnt < 255) m_ucnt++;
            m_bit = 0;
            m_rx  = '0;
         end
         chk("underrun", underrun, m_und);
         chk("ucount", underrun_count, 16'(m_ucnt));
         m_last = 1'b0;
         if (m_bit < 10) begin
            chk("s_out_bit", s_out, m_word[m_bit]);
            m_rx[m_bit] = s_out;
            m_bit++;
            if (m_bit == 10) begin
               m_last = 1'b1;
               chk("far_end_word", m_rx, m_word);
            end
         end else begin
            chk("s_out_idle", s_out, 0);
         end
         chk("load_ready", load_ready, (mq.size() == 0) || (m_last && tx_en));
         m_pend = (m_bit == 10) ? tx_en : 1'b0;
         // From IDLE the start word is fixed before any same-edge load; at a boundary a load may bypass
         if (m_pend && !m_last) take_word(1'b0);
         if (load_valid && load_ready) mq.push_back(parallel_in);
         if (m_pend && m_last) take_word(1'b1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [9:0] w);
      logic acc;
      int   budget;
      budget      = 50;
      load_valid  = 1'b1;
      parallel_in = w;
      do begin
         @(negedge clk);
         acc = load_ready;
         @(posedge clk);
         #1;
         budget--;
      end while (!acc && budget > 0);
      if (!acc) timeout("send");
      load_valid = 1'b0;
   endtask

   task automatic wait_start();
      int budget;
      budget = 40;
      do begin
         tick(1);
         budget--;
      end while (!cg_start && budget > 0);
      if (!cg_start) timeout("wait_start");
   endtask

   logic [9:0] w_held;
   logic [9:0] w_rst;

   initial begin
      reset       = 1'b1;
      tx_en       = 1'b0;
      load_valid  = 1'b0;
      parallel_in = '0;
      tick(3);
      reset = 1'b0;

      // Idle with nothing loaded
      tick(20);
      chk("idle_s_out", s_out, 0);
      chk("idle_load_ready", load_ready, 1);
      chk("idle_ucount", underrun_count, 0);

      // Preloaded 10'h2AA, then a single underrun
      send(10'h2AA);
      chk("preload_hold_full", load_ready, 0);
      tx_en = 1'b1;
      tick(1);
      chk("first_cg_start", cg_start, 1);
      chk("first_bit", s_out, 0);
      tick(1);
      chk("second_bit", s_out, 1);
      chk("second_cg_start", cg_start, 0);
      tick(9);
      chk("underrun_pulse", underrun, 1);
      chk("underrun_cg_start", cg_start, 1);
      chk("underrun_count_1", underrun_count, 1);
      tx_en = 1'b0;
      tick(12);
      chk("after_filler_idle", s_out, 0);

      // Back-to-back stream, no underrun
      send(K28_5_RDN);
      tx_en = 1'b1;
      send(K28_5_RDP);
      send(10'h0F0);
      chk("stream_hold_full", load_ready, 0);
      wait_start();
      tx_en = 1'b0;
      tick(15);
      chk("stream_no_underrun", underrun_count, 1);

      // Saturating underrun counter
      tx_en = 1'b1;
      tick(3010);
      chk("ucount_saturated", underrun_count, 8'hFF);
      tx_en = 1'b0;
      tick(15);

      // tx_en dropped mid-word: word completes, held word survives
      w_held = 10'($urandom);
      send(10'h3FF);
      tx_en = 1'b1;
      wait_start();
      send(w_held);
      tick(3);
      tx_en = 1'b0;
      tick(15);
      chk("stopped_s_out", s_out, 0);
      chk("stopped_cg_start", cg_start, 0);
      chk("stopped_hold_kept", load_ready, 0);
      tx_en = 1'b1;
      wait_start();
      chk("held_word_first_bit", s_out, w_held[0]);

      // Reset at bit 6 with the hold full
      w_rst = 10'($urandom);
      send(w_rst);
      tick(5);
      reset = 1'b1;
      #1;
      chk("async_rst_s_out", s_out, 0);
      chk("async_rst_load_ready", load_ready, 1);
      chk("async_rst_ucount", underrun_count, 0);
      tx_en = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(2);
      tx_en = 1'b1;
      wait_start();
      chk("restart_no_underrun", underrun, 0);
      chk("restart_filler_bit0", s_out, FILL[0]);
      tick(10);

      // Random traffic with occasional enable toggles
      for (int i = 0; i < 600; i++) begin
         load_valid  = ($urandom_range(0, 9) < 7);
         parallel_in = 10'($urandom);
         if ($urandom_range(0, 19) == 0) tx_en = !tx_en;
         tick(1);
      end

      load_valid = 1'b0;
      tx_en      = 1'b0;
      tick(25);
      chk("final_idle", s_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
